// File: rtl/io_stage_params.sv
// rtl/io_stage_params.sv - shared types for the IO (memory-access) pipeline stage
package io_stage_params;

  typedef logic [31:0] cpu_data_t;
  typedef logic [31:0] program_count_t;
  typedef logic [4:0]  register_index_t;

  typedef enum logic [2:0] {
    MEM_BYTE,
    MEM_HALF,
    MEM_WORD,
    MEM_LEFT,
    MEM_RIGHT
  } memory_size_t;

  typedef enum logic [1:0] {
    EMPTY,
    WAIT,
    READY
  } io_state_t;

  // Only the byte offset of the address survives past EX; the full address lives in badvaddr.
  typedef struct packed {
    logic            valid;
    program_count_t  program_count;
    logic            in_delay_slot;
    logic            exception_valid;
    logic [4:0]      exception_code;
    cpu_data_t       badvaddr;
    logic            eret;
    logic            move_from_cp0;
    logic            move_to_cp0;
    logic [7:0]      cp0_address;
    logic            hi_write;
    logic            lo_write;
    cpu_data_t       hi_result;
    cpu_data_t       lo_result;
    logic            result_is_from_memory;
    logic            memory_write;
    memory_size_t    memory_size;
    logic            memory_io_unsigned;
    logic [1:0]      memory_address;
    cpu_data_t       multi_use_register_data;
    cpu_data_t       alu_result;
    logic            register_write;
    register_index_t write_register;
  } ex_to_io_bus_t;

  typedef struct packed {
    logic            valid;
    program_count_t  program_count;
    logic            in_delay_slot;
    logic            exception_valid;
    logic [4:0]      exception_code;
    cpu_data_t       badvaddr;
    logic            eret;
    logic            move_from_cp0;
    logic            move_to_cp0;
    logic [7:0]      cp0_address;
    cpu_data_t       cp0_write_data;
    logic            hi_write;
    logic            lo_write;
    cpu_data_t       hi_result;
    cpu_data_t       lo_result;
    logic            register_write;
    register_index_t write_register;
    cpu_data_t       write_data;
  } io_to_wb_bus_t;

  typedef struct packed {
    logic            valid;
    logic            data_valid;
    register_index_t write_register;
    cpu_data_t       write_data;
  } io_to_id_back_pass_bus_t;

  function automatic logic needs_response(input ex_to_io_bus_t bus);
    return bus.valid & ~bus.exception_valid & (bus.result_is_from_memory | bus.memory_write);
  endfunction

endpackage

// File: rtl/load_data_aligner.sv
// rtl/load_data_aligner.sv - aligns and extends raw load data by size and byte offset
module load_data_aligner
  import io_stage_params::*;
(
  input  memory_size_t memory_size,
  input  logic         memory_io_unsigned,
  input  logic [1:0]   byte_offset,
  input  cpu_data_t    memory_data,
  input  cpu_data_t    register_data,
  output cpu_data_t    aligned_data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  cpu_data_t   left_data;
  cpu_data_t   right_data;

  always_comb begin
    case (byte_offset)
      2'd0: sel_byte = memory_data[7:0];
      2'd1: sel_byte = memory_data[15:8];
      2'd2: sel_byte = memory_data[23:16];
      default: sel_byte = memory_data[31:24];
    endcase
    sel_half = byte_offset[1] ? memory_data[31:16] : memory_data[15:0];

    // Unaligned word loads merge memory bytes into the old register value.
    case (byte_offset)
      2'd0: left_data = {memory_data[7:0], register_data[23:0]};
      2'd1: left_data = {memory_data[15:0], register_data[15:0]};
      2'd2: left_data = {memory_data[23:0], register_data[7:0]};
      default: left_data = memory_data;
    endcase
    case (byte_offset)
      2'd0: right_data = memory_data;
      2'd1: right_data = {register_data[31:24], memory_data[31:8]};
      2'd2: right_data = {register_data[31:16], memory_data[31:16]};
      default: right_data = {register_data[31:8], memory_data[31:24]};
    endcase

    case (memory_size)
      MEM_BYTE:  aligned_data = {{24{sel_byte[7] & ~memory_io_unsigned}}, sel_byte};
      MEM_HALF:  aligned_data = {{16{sel_half[15] & ~memory_io_unsigned}}, sel_half};
      MEM_LEFT:  aligned_data = left_data;
      MEM_RIGHT: aligned_data = right_data;
      default:   aligned_data = memory_data;
    endcase
  end

endmodule

// File: rtl/io_stage.sv
// rtl/io_stage.sv - memory-access stage: waits for data-RAM responses and hands results to WB
module io_stage
  import io_stage_params::*;
#(
  parameter int CANCEL_COUNTER_WIDTH = 2
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    ex_to_io_valid,
  input  ex_to_io_bus_t           ex_to_io_bus,
  output logic                    io_allow_in,
  input  logic                    data_ram_data_ok,
  input  cpu_data_t               data_ram_read_data,
  input  logic                    exception_flush,
  input  logic                    wb_allow_in,
  output logic                    io_to_wb_valid,
  output io_to_wb_bus_t           io_to_wb_bus,
  output io_to_id_back_pass_bus_t io_to_id_back_pass_bus
);

  localparam logic [CANCEL_COUNTER_WIDTH-1:0] CANCEL_MAX = '1;

  logic                            io_valid_q, io_valid_d;
  ex_to_io_bus_t                   payload_q, payload_d;
  io_state_t                       state_q, state_d;
  cpu_data_t                       load_buffer_q, load_buffer_d;
  logic [CANCEL_COUNTER_WIDTH-1:0] cancel_count_q, cancel_count_d;

  logic      io_ready_go;
  logic      accept;
  logic      response_live;
  logic      cancel_inc;
  logic      cancel_dec;
  cpu_data_t aligned_data;
  cpu_data_t write_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      io_valid_q     <= 1'b0;
      payload_q      <= '0;
      state_q        <= EMPTY;
      load_buffer_q  <= '0;
      cancel_count_q <= '0;
    end else begin
      io_valid_q     <= io_valid_d;
      payload_q      <= payload_d;
      state_q        <= state_d;
      load_buffer_q  <= load_buffer_d;
      cancel_count_q <= cancel_count_d;
    end
  end

  always_comb begin
    accept        = io_allow_in & ex_to_io_valid;
    response_live = data_ram_data_ok & (cancel_count_q == '0);
    // A flushed request still owes a response unless it arrives in the flush cycle itself.
    cancel_inc    = exception_flush & (state_q == WAIT) & ~response_live;
    cancel_dec    = data_ram_data_ok & (cancel_count_q != '0);

    io_valid_d     = io_valid_q;
    payload_d      = payload_q;
    state_d        = state_q;
    load_buffer_d  = load_buffer_q;
    cancel_count_d = cancel_count_q;

    if (cancel_inc && !cancel_dec) begin
      cancel_count_d = cancel_count_q + CANCEL_COUNTER_WIDTH'(1);
    end else if (!cancel_inc && cancel_dec) begin
      cancel_count_d = cancel_count_q - CANCEL_COUNTER_WIDTH'(1);
    end

    if (state_q == WAIT && response_live) begin
      load_buffer_d = data_ram_read_data;
    end

    if (exception_flush) begin
      io_valid_d = 1'b0;
      state_d    = EMPTY;
    end else if (accept) begin
      io_valid_d = 1'b1;
      payload_d  = ex_to_io_bus;
      state_d    = needs_response(ex_to_io_bus) ? WAIT : READY;
    end else if (io_to_wb_valid && wb_allow_in) begin
      io_valid_d = 1'b0;
      state_d    = EMPTY;
    end else if (state_q == WAIT && response_live) begin
      state_d = READY;
    end
  end

  load_data_aligner u_load_data_aligner (
    .memory_size        (payload_q.memory_size),
    .memory_io_unsigned (payload_q.memory_io_unsigned),
    .byte_offset        (payload_q.memory_address),
    .memory_data        (load_buffer_q),
    .register_data      (payload_q.multi_use_register_data),
    .aligned_data       (aligned_data)
  );

  always_comb begin
    io_ready_go    = (state_q == READY);
    io_allow_in    = ~io_valid_q | (io_ready_go & wb_allow_in);
    io_to_wb_valid = io_valid_q & io_ready_go & ~exception_flush;
    write_data     = payload_q.result_is_from_memory ? aligned_data : payload_q.alu_result;

    io_to_wb_bus                 = '0;
    io_to_wb_bus.valid           = io_valid_q & payload_q.valid;
    io_to_wb_bus.program_count   = payload_q.program_count;
    io_to_wb_bus.in_delay_slot   = payload_q.in_delay_slot;
    io_to_wb_bus.exception_valid = payload_q.exception_valid;
    io_to_wb_bus.exception_code  = payload_q.exception_code;
    io_to_wb_bus.badvaddr        = payload_q.badvaddr;
    io_to_wb_bus.eret            = payload_q.eret;
    io_to_wb_bus.move_from_cp0   = payload_q.move_from_cp0;
    io_to_wb_bus.move_to_cp0     = payload_q.move_to_cp0;
    io_to_wb_bus.cp0_address     = payload_q.cp0_address;
    io_to_wb_bus.cp0_write_data  = payload_q.multi_use_register_data;
    io_to_wb_bus.hi_write        = payload_q.hi_write;
    io_to_wb_bus.lo_write        = payload_q.lo_write;
    io_to_wb_bus.hi_result       = payload_q.hi_result;
    io_to_wb_bus.lo_result       = payload_q.lo_result;
    io_to_wb_bus.register_write  = payload_q.register_write;
    io_to_wb_bus.write_register  = payload_q.write_register;
    io_to_wb_bus.write_data      = write_data;

    io_to_id_back_pass_bus.valid          = io_valid_q & payload_q.register_write &
                                            (payload_q.write_register != '0);
    io_to_id_back_pass_bus.data_valid     = io_ready_go & ~payload_q.move_from_cp0;
    io_to_id_back_pass_bus.write_register = payload_q.write_register;
    io_to_id_back_pass_bus.write_data     = write_data;
  end

  a_data_ok_expected: assert property (@(posedge clock) disable iff (!reset_n)
    (data_ram_data_ok && cancel_count_q == '0) |-> (state_q == WAIT));

  a_cancel_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(cancel_inc && !cancel_dec && cancel_count_q == CANCEL_MAX));

endmodule
